dcache_wb: RTL
==============

# dcache_wb

Data-memory responder for the core's data-cache port: the other end of the core's `o_we` / `o_DcacheAddr` / `o_data` / `i_DcacheData` interface. Stores are accepted into a small in-order store buffer and drained into a word-addressed storage array. Loads are answered combinationally, with store-to-load forwarding from the buffer. It replaces the flat data memory in core-level benches. It also gives back-pressure via `o_busy` for the core's store path.

## Interface
Parameters:
- `WIDTH`, 12: byte-address width; storage holds 2**(WIDTH-2) 32-bit words.
- `SB_LOG`, 2: log2 of store-buffer depth (default 4 entries).

Ports:
- Clocking and reset (already decided): one clock, `i_clk`; reset `i_rst_n`, asynchronous, active-low.
- `i_clk`, input, 1: clock; all state updates on the rising edge.
- `i_rst_n`, input, 1: asynchronous active-low reset.
- `i_we`, input, 1: store request this cycle (connects to core `o_we`).
- `i_addr`, input, WIDTH: byte address for both store and load (core `o_DcacheAddr`). Bits [1:0] are ignored.
- `i_data`, input, 32: store data (core `o_data`).
- `o_data`, output, 32: load data for `i_addr` (core `i_DcacheData`).
- `o_busy`, output, 1: store buffer full; a store presented this cycle is refused.
- `o_empty`, output, 1: store buffer empty; all accepted stores are in the array.

## Operation
- Word index is `i_addr[WIDTH-1:2]`. Storage array size is 2**(WIDTH-2) x 32. The array is not reset.
- Store buffer: circular FIFO of 2**SB_LOG entries {word index, data}.
  - Head and tail pointers are SB_LOG bits wide and wrap modulo depth.
  - The occupancy counter is SB_LOG+1 bits wide.
- Accept: at a rising edge with `i_we`=1 and `o_busy`=0, the entry is written at the tail, the tail advances and the count increments.
  - With `o_busy`=1 the store is dropped; the core holds `i_we`, `i_addr` and `i_data` until accepted.
- Drain condition: count≠0 and (`i_we`=0 or count==depth).
  - Idle cycles drain the buffer. Back-to-back stores fill it. A full buffer always drains, so there is no deadlock.
- Drain action: when the condition holds at an edge, the head entry is written to the array, the head advances and the count decrements.
- Simultaneous accept and drain (non-full, `i_we`=1) cannot occur: drain waits.
- Full + `i_we`=1: that edge drains only, with no accept. The next edge accepts, because the buffer is no longer full.
- Load path is combinational from `i_addr`:
  - If any valid buffer entry matches the word index, `o_data` is the data of the youngest matching entry (nearest to the tail).
  - Otherwise `o_data` is the array word.
  - `o_data` is always driven, regardless of `i_we`.
- `o_busy` = (count == depth); `o_empty` = (count == 0). Both are combinational from the count.
- Reset (asynchronous, any time): head=tail=count=0, `o_busy`=0, `o_empty`=1.
  - Pending entries are discarded, not drained. Array contents are unchanged.
  - A store in flight at reset assertion is lost.

## Timing
- Store accept latency: data accepted at edge N is visible on `o_data` for that address from cycle N+1 onward, via forwarding until drained, then from the array.
- No visibility gap between buffer and array: a drain at edge M updates the array and removes the entry at the same edge.
- Drain throughput: one entry per edge. A full buffer empties in 2**SB_LOG idle cycles.
- `o_busy` rises the cycle after the accept that fills the buffer. It falls the cycle after the forced drain.
- Load latency is zero cycles: `o_data` settles combinationally within the cycle from `i_addr` and the current state.

## Test plan
- Reset: assert `i_rst_n`=0 for 1 ns at t=0 → `o_busy`=0, `o_empty`=1, count=0.
- Forward then drain: store 0xDEADBEEF to 0x010, then `i_we`=0 with `i_addr`=0x010.
  - Required: `o_data`=0xDEADBEEF the cycle after the accept, while `o_empty`=0.
  - After one idle edge: `o_empty`=1 and `o_data` still 0xDEADBEEF.
  - Reading at 0x013 also returns 0xDEADBEEF.
- Fill/back-pressure: stores to 0x000/0x004/0x008/0x00C with data 1..4 back-to-back, then a 5th store (0x010, data 5) held.
  - Required: `o_busy`=1 after the 4th accept; the 5th is accepted exactly one edge later.
  - All five addresses read 1..5.
- Youngest-match forwarding: stores 0x1111 then 0x2222 to 0x020 back-to-back.
  - Required: read of 0x020 returns 0x2222.
  - After draining both entries: array word 8 = 0x2222.
- Pointer wrap: 10 stores to distinct addresses, each followed by one idle cycle, plus one burst of 3.
  - Required: every address reads its own data, and drain order matches accept order across the pointer wrap.
- Reset mid-operation: preload 0x030 = 0xAAAA (store + drain), then 3 buffered stores including 0x030 = 0xBBBB, then assert reset.
  - Required: `o_empty`=1, and 0x030 reads 0xAAAA.

Source files
------------

// File: rtl/dcache_wb.sv
// rtl/dcache_wb.sv - data-cache port responder with in-order store buffer and load forwarding
`timescale 1ns / 1ps
module dcache_wb #(
  parameter int WIDTH  = 12,
  parameter int SB_LOG = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_addr,
  input  logic [31:0]      i_data,
  output logic [31:0]      o_data,
  output logic             o_busy,
  output logic             o_empty
);
  localparam int DEPTH = 1 << SB_LOG;
  localparam int IW    = WIDTH - 2;

  logic [31:0]       mem_q     [2**IW];
  logic [IW-1:0]     sb_idx_q  [DEPTH];
  logic [31:0]       sb_data_q [DEPTH];
  logic [SB_LOG-1:0] head_q, head_d;
  logic [SB_LOG-1:0] tail_q, tail_d;
  logic [SB_LOG:0]   count_q, count_d;
  logic [IW-1:0]     word_idx;
  logic              accept, drain;
  logic              unused_addr_bits;

  assign word_idx         = i_addr[WIDTH-1:2];
  assign unused_addr_bits = ^i_addr[1:0];

  assign o_busy  = (count_q == (SB_LOG+1)'(DEPTH));
  assign o_empty = (count_q == '0);
  // A full buffer drains even with a store pending, so the core can never stall forever.
  assign accept  = i_we && !o_busy;
  assign drain   = !o_empty && (!i_we || o_busy);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (accept) begin
      tail_d  = tail_q + SB_LOG'(1);
      count_d = count_q + (SB_LOG+1)'(1);
    end else if (drain) begin
      head_d  = head_q + SB_LOG'(1);
      count_d = count_q - (SB_LOG+1)'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Buffer payload and the array carry no reset; validity comes from the pointers.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      sb_idx_q[tail_q]  <= word_idx;
      sb_data_q[tail_q] <= i_data;
    end
    if (drain) begin
      mem_q[sb_idx_q[head_q]] <= sb_data_q[head_q];
    end
  end

  // Walk oldest to youngest so the last match found is the youngest store.
  always_comb begin
    logic [SB_LOG-1:0] ptr;
    ptr    = head_q;
    o_data = mem_q[word_idx];
    for (int k = 0; k < DEPTH; k++) begin
      ptr = head_q + SB_LOG'(k);
      if (((SB_LOG+1)'(k) < count_q) && (sb_idx_q[ptr] == word_idx)) begin
        o_data = sb_data_q[ptr];
      end
    end
  end
endmodule
